// File: rtl/regfile_port_arbiter.sv
// Single-port owner for the 16x16 register file: post-reset scrub, then round-robin
// sharing between the core datapath (req0) and the debug/host port (req1).
module regfile_port_arbiter #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned REGBITS  = 4,
  parameter bit          SCRUB_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               we0,
  input  logic [REGBITS-1:0] ra10,
  input  logic [REGBITS-1:0] ra20,
  input  logic [WIDTH-1:0]   wd0,
  input  logic               req1,
  input  logic               we1,
  input  logic [REGBITS-1:0] ra11,
  input  logic [REGBITS-1:0] ra21,
  input  logic [WIDTH-1:0]   wd1,
  output logic               gnt0,
  output logic               gnt1,
  output logic [WIDTH-1:0]   rd10,
  output logic [WIDTH-1:0]   rd20,
  output logic [WIDTH-1:0]   rd11,
  output logic [WIDTH-1:0]   rd21,
  output logic               valid0,
  output logic               valid1,
  output logic               busy,
  output logic               rf_regwrite,
  output logic [REGBITS-1:0] rf_ra1,
  output logic [REGBITS-1:0] rf_ra2,
  output logic [WIDTH-1:0]   rf_wd,
  input  logic [WIDTH-1:0]   rf_rd1,
  input  logic [WIDTH-1:0]   rf_rd2
);

  typedef enum logic [0:0] {StScrub, StArb} state_e;

  localparam logic [REGBITS-1:0] LastReg = '1;
  localparam state_e ResetState = SCRUB_EN ? StScrub : StArb;

  state_e             state_q, state_d;
  logic [REGBITS-1:0] cnt_q, cnt_d;
  logic               last_q, last_d;  // 1 = requester 1 was granted most recently

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    busy        = 1'b0;
    rf_regwrite = 1'b0;
    rf_ra1      = '0;
    rf_ra2      = '0;
    rf_wd       = '0;
    if (!reset) begin
      // Port held quiet combinationally so an in-flight write cannot commit.
      busy = 1'b1;
    end else begin
      unique case (state_q)
        StScrub: begin
          busy        = 1'b1;
          rf_regwrite = 1'b1;
          rf_ra2      = cnt_q;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LastReg) state_d = StArb;
        end
        StArb: begin
          gnt0 = req0 & (~req1 | last_q);
          gnt1 = req1 & (~req0 | ~last_q);
          if (gnt0) begin
            rf_regwrite = we0;
            rf_ra1      = ra10;
            rf_ra2      = ra20;
            rf_wd       = wd0;
            last_d      = 1'b0;
          end else if (gnt1) begin
            rf_regwrite = we1;
            rf_ra1      = ra11;
            rf_ra2      = ra21;
            rf_wd       = wd1;
            last_d      = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ResetState;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Read data is sampled at the grant edge, so a same-access write returns the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd10   <= '0;
      rd20   <= '0;
      rd11   <= '0;
      rd21   <= '0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
    end else begin
      valid0 <= gnt0;
      valid1 <= gnt1;
      if (gnt0) begin
        rd10 <= rf_rd1;
        rd20 <= rf_rd2;
      end
      if (gnt1) begin
        rd11 <= rf_rd1;
        rd21 <= rf_rd2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: directed scenarios plus a randomized
// two-requester phase checked against a behavioural register-file/arbitration model.
module tb_regfile_port_arbiter;
  localparam int W  = 16;
  localparam int RB = 4;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          req_v[2];
  logic          we_v[2];
  logic [RB-1:0] ra1_v[2];
  logic [RB-1:0] ra2_v[2];
  logic [W-1:0]  wd_v[2];

  logic          gnt0, gnt1, valid0, valid1, busy, rf_regwrite;
  logic [W-1:0]  rd10, rd20, rd11, rd21, rf_wd, rf_rd1, rf_rd2;
  logic [RB-1:0] rf_ra1, rf_ra2;

  // Register file environment: combinational read, register 0 reads as 0.
  logic [W-1:0] rf_mem[N];
  logic         rf_seeded = 1'b0;
  always @(posedge clk) begin
    if (!rf_seeded) begin
      for (int i = 0; i < N; i++) rf_mem[i] <= W'($urandom);
      rf_seeded <= 1'b1;
    end else if (rf_regwrite) begin
      rf_mem[rf_ra2] <= rf_wd;
    end
  end
  assign rf_rd1 = (rf_ra1 == '0) ? '0 : rf_mem[rf_ra1];
  assign rf_rd2 = (rf_ra2 == '0) ? '0 : rf_mem[rf_ra2];

  regfile_port_arbiter #(.WIDTH(W), .REGBITS(RB), .SCRUB_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0(req_v[0]), .we0(we_v[0]), .ra10(ra1_v[0]), .ra20(ra2_v[0]), .wd0(wd_v[0]),
    .req1(req_v[1]), .we1(we_v[1]), .ra11(ra1_v[1]), .ra21(ra2_v[1]), .wd1(wd_v[1]),
    .gnt0(gnt0), .gnt1(gnt1), .rd10(rd10), .rd20(rd20), .rd11(rd11), .rd21(rd21),
    .valid0(valid0), .valid1(valid1), .busy(busy), .rf_regwrite(rf_regwrite),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wd(rf_wd), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: architectural register contents, expected captured data, last winner.
  logic [W-1:0] m_mem[N];
  logic [W-1:0] e_rd1[2];
  logic [W-1:0] e_rd2[2];
  int           e_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input logic r, input logic we, input logic [RB-1:0] a1,
                       input logic [RB-1:0] a2, input logic [W-1:0] d);
    req_v[n] = r;
    we_v[n]  = we;
    ra1_v[n] = a1;
    ra2_v[n] = a2;
    wd_v[n]  = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    for (int i = 0; i < 2; i++) begin
      e_rd1[i] = '0;
      e_rd2[i] = '0;
    end
    e_last = 1;
  endtask

  function automatic logic [W-1:0] m_read(input logic [RB-1:0] a);
    return (a == '0) ? '0 : m_mem[a];
  endfunction

  // One ARB cycle: check grant and port drive, advance the model, check captured results.
  task automatic cycle_check(output int winner);
    int w;
    #1;
    w = -1;
    if (req_v[0] && req_v[1]) w = (e_last == 0) ? 1 : 0;
    else if (req_v[0]) w = 0;
    else if (req_v[1]) w = 1;
    chk("gnt0", gnt0, w == 0);
    chk("gnt1", gnt1, w == 1);
    chk("busy_arb", busy, 0);
    if (w >= 0) begin
      chk("rf_regwrite", rf_regwrite, we_v[w]);
      chk("rf_ra1", rf_ra1, ra1_v[w]);
      chk("rf_ra2", rf_ra2, ra2_v[w]);
      chk("rf_wd", rf_wd, wd_v[w]);
      e_rd1[w] = m_read(ra1_v[w]);
      e_rd2[w] = m_read(ra2_v[w]);
      if (we_v[w]) m_mem[ra2_v[w]] = wd_v[w];
      e_last = w;
    end else begin
      chk("idle_regwrite", rf_regwrite, 0);
      chk("idle_ra1", rf_ra1, 0);
      chk("idle_ra2", rf_ra2, 0);
      chk("idle_wd", rf_wd, 0);
    end
    step();
    chk("valid0", valid0, w == 0);
    chk("valid1", valid1, w == 1);
    chk("rd10", rd10, e_rd1[0]);
    chk("rd20", rd20, e_rd2[0]);
    chk("rd11", rd11, e_rd1[1]);
    chk("rd21", rd21, e_rd2[1]);
    winner = w;
  endtask

  task automatic scrub_check(input string tag);
    for (int i = 0; i < N; i++) begin
      #1;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_gnt0"}, gnt0, 0);
      chk({tag, "_gnt1"}, gnt1, 0);
      chk({tag, "_we"}, rf_regwrite, 1);
      chk({tag, "_ra2"}, rf_ra2, i);
      chk({tag, "_ra1"}, rf_ra1, 0);
      chk({tag, "_wd"}, rf_wd, 0);
      chk({tag, "_rd10"}, rd10, 0);
      step();
    end
    for (int i = 0; i < N; i++) chk({tag, "_mem"}, rf_mem[i], 0);
  endtask

  initial begin
    int w;
    logic [RB-1:0] a;
    drive(0, 1'b1, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    model_reset();

    // Held in reset: port quiet, outputs cleared.
    repeat (3) step();
    chk("rst_busy", busy, 1);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_regwrite", rf_regwrite, 0);
    chk("rst_valid0", valid0, 0);
    chk("rst_rd10", rd10, 0);
    chk("rst_rd21", rd21, 0);

    // Scrub with req0 held: 16 busy cycles, then first grant on cycle 17.
    reset = 1'b1;
    scrub_check("scrub");

    // Both requesting from the first ARB cycle: strict alternation starting with 0.
    a = RB'($urandom);
    drive(1, 1'b1, 1'b0, a, 4'd2, '0);
    for (int k = 0; k < 6; k++) begin
      cycle_check(w);
      chk("tie_seq", w, k % 2);
    end
    drive(1, 1'b0, 1'b0, '0, '0, '0);

    // Write then read back through requester 0.
    drive(0, 1'b1, 1'b1, 4'd0, 4'd3, 16'hBEEF);
    cycle_check(w);
    drive(0, 1'b1, 1'b0, 4'd3, 4'd0, 16'h0000);
    cycle_check(w);
    chk("t2_rd10", rd10, 16'hBEEF);

    // Read-during-write returns the old value; new value visible next access.
    drive(0, 1'b1, 1'b1, 4'd0, 4'd5, 16'h0011);
    cycle_check(w);
    drive(0, 1'b1, 1'b1, 4'd5, 4'd5, 16'h2222);
    cycle_check(w);
    chk("t4_rd1_old", rd10, 16'h0011);
    chk("t4_rd2_old", rd20, 16'h0011);
    drive(0, 1'b1, 1'b0, 4'd5, 4'd5, 16'h0000);
    cycle_check(w);
    chk("t4_rd1_new", rd10, 16'h2222);

    // Register 0 always reads zero.
    drive(0, 1'b1, 1'b1, 4'd0, 4'd0, 16'hFFFF);
    cycle_check(w);
    drive(0, 1'b1, 1'b0, 4'd0, 4'd0, 16'h0000);
    cycle_check(w);
    chk("t5_rd1", rd10, 16'h0000);
    chk("t5_rd2", rd20, 16'h0000);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    cycle_check(w);

    // Randomized traffic: requests held until granted, occasional aborts, back-to-back reissue.
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req_v[n] && $urandom_range(0, 2) != 0)
          drive(n, 1'b1, 1'($urandom_range(0, 1)), RB'($urandom), RB'($urandom), W'($urandom));
        else if (req_v[n] && $urandom_range(0, 15) == 0)
          req_v[n] = 1'b0;
      end
      cycle_check(w);
      if (w >= 0) req_v[w] = 1'b0;
    end

    // Reset during a granted write: no commit, outputs cleared, scrub reruns.
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    drive(0, 1'b1, 1'b1, 4'd0, 4'd7, 16'h1234);
    #1;
    chk("t6_gnt_pre", gnt0, 1);
    chk("t6_we_pre", rf_regwrite, 1);
    reset = 1'b0;
    #1;
    chk("t6_gnt_drop", gnt0, 0);
    chk("t6_we_drop", rf_regwrite, 0);
    chk("t6_busy", busy, 1);
    chk("t6_valid0", valid0, 0);
    chk("t6_rd10", rd10, 0);
    chk("t6_rd11", rd11, 0);
    step();
    chk("t6_nocommit", rf_mem[7], m_mem[7]);
    reset = 1'b1;
    scrub_check("rescrub");
    model_reset();
    cycle_check(w);
    chk("t6_first_win", w, 0);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    cycle_check(w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
